// File: rtl/d_pipe_reg.sv
// d_pipe_reg: WIDTH-bit, DEPTH-stage registered delay line with per-stage valid
// tracking, stall, flush, run-time selectable output tap (including a zero-latency
// bypass) and a registered occupancy count.
module d_pipe_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      LW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [LW-1:0]    lat_sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [LW-1:0]    count
);

  localparam logic [LW-1:0] DepthSel = LW'(DEPTH);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [LW-1:0]    count_q, count_d;
  logic [LW-1:0]    lat_eff;

  // Next state: flush beats shift beats hold; flush leaves data untouched.
  always_comb begin
    s_d     = s_q;
    v_d     = v_q;
    count_d = count_q;
    if (flush) begin
      v_d     = '0;
      count_d = '0;
    end else if (en) begin
      s_d[0] = din;
      v_d[0] = din_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        s_d[i] = s_q[i-1];
        v_d[i] = v_q[i-1];
      end
      // Occupancy tracks the popcount of v incrementally: one in, oldest out.
      count_d = count_q + LW'(din_valid) - LW'(v_q[DEPTH-1]);
    end
  end

  // State registers with asynchronous reset to RESET_VAL / invalid / empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        s_q[i] <= RESET_VAL;
      end
      v_q     <= '0;
      count_q <= '0;
    end else begin
      s_q     <= s_d;
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  // Output tap: bypass at 0, stage k-1 for k >= 1, clamped to the last stage.
  always_comb begin
    lat_eff    = (lat_sel > DepthSel) ? DepthSel : lat_sel;
    dout       = din;
    dout_valid = din_valid & ~flush;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      if (lat_eff == LW'(k)) begin
        dout       = s_q[k-1];
        dout_valid = v_q[k-1];
      end
    end
    // Bypass is combinational, so reset must mask it explicitly.
    if (!rst_n) begin
      dout       = RESET_VAL;
      dout_valid = 1'b0;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_d_pipe_reg.sv
// Self-checking bench for d_pipe_reg: reset/stream/stall table, hand-written
// bubble, flush, bypass/clamp and tap-switch sequences, then randomized traffic
// against a queue-based reference model.
module tb_d_pipe_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             en        = 1'b0;
  logic             flush     = 1'b0;
  logic             din_valid = 1'b0;
  logic [WIDTH-1:0] din       = '0;
  logic [LW-1:0]    lat_sel   = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [LW-1:0]    count;

  int checks = 0;
  int errors = 0;

  d_pipe_reg #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VAL(8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .din_valid (din_valid),
    .din       (din),
    .lat_sel   (lat_sel),
    .dout      (dout),
    .dout_valid(dout_valid),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of in-flight words, index 0 = newest (tap 1).
  typedef struct {
    logic [WIDTH-1:0] d;
    logic             v;
  } ent_t;
  ent_t pipe[$];

  typedef struct {
    logic             en;
    logic             dv;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_d;
    logic             exp_v;
    logic [LW-1:0]    exp_c;
  } vec_t;
  vec_t tbl[11];

  int          b_cnt[7] = '{1, 1, 2, 2, 1, 1, 0};
  logic        b_v[7]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0]  b_d[7]   = '{8'h01, 8'hEE, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic vec_t mk(logic e, logic dv, logic [7:0] d, logic [7:0] ed, logic ev,
                              logic [2:0] ec);
    vec_t r;
    r.en = e; r.dv = dv; r.din = d; r.exp_d = ed; r.exp_v = ev; r.exp_c = ec;
    return r;
  endfunction

  function automatic void model_reset();
    ent_t e;
    e.d = '0;
    e.v = 1'b0;
    pipe.delete();
    for (int i = 0; i < int'(DEPTH); i++) pipe.push_back(e);
  endfunction

  function automatic void model_edge();
    ent_t e;
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      foreach (pipe[i]) pipe[i].v = 1'b0;
    end else if (en) begin
      e.d = din;
      e.v = din_valid;
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_check(input string tag);
    int unsigned k;
    int unsigned c;
    logic [WIDTH-1:0] ed;
    logic ev;
    k = int'(lat_sel);
    if (k > DEPTH) k = DEPTH;
    if (k == 0) begin
      ed = din;
      ev = din_valid & ~flush;
    end else begin
      ed = pipe[k-1].d;
      ev = pipe[k-1].v;
    end
    c = 0;
    foreach (pipe[i]) if (pipe[i].v) c++;
    check({tag, "_dout"}, 32'(dout), 32'(ed));
    check({tag, "_valid"}, 32'(dout_valid), 32'(ev));
    check({tag, "_count"}, 32'(count), c);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, checked immediately, released on negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_rst_dout"}, 32'(dout), 32'h0);
    check({tag, "_rst_valid"}, 32'(dout_valid), 32'h0);
    check({tag, "_rst_count"}, 32'(count), 32'h0);
    lat_sel   = '0;
    din       = 8'h5A;
    din_valid = 1'b1;
    flush     = 1'b0;
    #1;
    check({tag, "_rst_bypass_dout"}, 32'(dout), 32'h0);
    check({tag, "_rst_bypass_valid"}, 32'(dout_valid), 32'h0);
    en        = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1 stimulus table (lat_sel = 3), including the stall of test 2.
    tbl[0]  = mk(1, 1, 8'h11, 8'h00, 0, 0);
    tbl[1]  = mk(1, 1, 8'h22, 8'h00, 0, 1);
    tbl[2]  = mk(1, 1, 8'h33, 8'h00, 0, 2);
    tbl[3]  = mk(1, 1, 8'h44, 8'h11, 1, 3);
    tbl[4]  = mk(0, 1, 8'hAA, 8'h22, 1, 4);
    tbl[5]  = mk(0, 1, 8'hAA, 8'h22, 1, 4);
    tbl[6]  = mk(1, 0, 8'h00, 8'h22, 1, 4);
    tbl[7]  = mk(1, 0, 8'h00, 8'h33, 1, 3);
    tbl[8]  = mk(1, 0, 8'h00, 8'h44, 1, 2);
    tbl[9]  = mk(1, 0, 8'h00, 8'h00, 0, 1);
    tbl[10] = mk(0, 0, 8'h00, 8'h00, 0, 0);

    model_reset();
    #12;
    rst_n = 1'b1;

    // Put words in flight so the mid-cycle reset has something to discard.
    en = 1'b1; din_valid = 1'b1; lat_sel = 3'd1;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'hC0 + i);
      tick();
    end
    check("pre_rst_count", 32'(count), 32'd3);
    do_reset("t1");

    // Tests 1 and 2: stream through tap 3 with a two-cycle stall.
    lat_sel = 3'd3;
    flush   = 1'b0;
    for (int i = 0; i < 11; i++) begin
      en        = tbl[i].en;
      din_valid = tbl[i].dv;
      din       = tbl[i].din;
      #2;
      check($sformatf("t1_row%0d_dout", i), 32'(dout), 32'(tbl[i].exp_d));
      check($sformatf("t1_row%0d_valid", i), 32'(dout_valid), 32'(tbl[i].exp_v));
      check($sformatf("t1_row%0d_count", i), 32'(count), 32'(tbl[i].exp_c));
      tick();
    end

    // Test 3: bubbles and occupancy, observed at tap 2.
    lat_sel = 3'd2;
    en      = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din       = b_d[i];
      din_valid = b_v[i];
      tick();
      check($sformatf("t3_edge%0d_count", i), 32'(count), b_cnt[i]);
      if (i == 1) begin
        check("t3_tap2_word1_dout", 32'(dout), 32'h01);
        check("t3_tap2_word1_valid", 32'(dout_valid), 32'h1);
      end
      if (i == 2) begin
        check("t3_tap2_bubble_dout", 32'(dout), 32'hEE);
        check("t3_tap2_bubble_valid", 32'(dout_valid), 32'h0);
      end
    end

    // Test 4: flush beats a simultaneous valid shift.
    lat_sel = 3'd4;
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'(8'hB1 + i);
      tick();
    end
    check("t4_full_count", 32'(count), 32'd4);
    flush = 1'b1; din = 8'h55; din_valid = 1'b1; en = 1'b1;
    tick();
    flush = 1'b0; din_valid = 1'b0; en = 1'b0;
    check("t4_flush_count", 32'(count), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      lat_sel = 3'(k);
      #1;
      check($sformatf("t4_flush_tap%0d_valid", k), 32'(dout_valid), 32'h0);
      if (k == 1) check("t4_flush_tap1_held", 32'(dout), 32'hB4);
    end
    en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      for (int k = 1; k <= 4; k++) begin
        lat_sel = 3'(k);
        #1;
        check($sformatf("t4_drain%0d_tap%0d_valid", t, k), 32'(dout_valid), 32'h0);
      end
    end

    // Test 5: bypass (also while stalled) and lat_sel clamp.
    en = 1'b0; lat_sel = 3'd0; din = 8'h7E; din_valid = 1'b1;
    #1;
    check("t5_bypass_dout", 32'(dout), 32'h7E);
    check("t5_bypass_valid", 32'(dout_valid), 32'h1);
    flush = 1'b1;
    #1;
    check("t5_bypass_flush_dout", 32'(dout), 32'h7E);
    check("t5_bypass_flush_valid", 32'(dout_valid), 32'h0);
    flush = 1'b0;
    tick();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'(8'hA1 + i);
      tick();
    end
    en = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      lat_sel = 3'(k);
      #1;
      check($sformatf("t5_clamp%0d_dout", k), 32'(dout), 32'hA1);
      check($sformatf("t5_clamp%0d_valid", k), 32'(dout_valid), 32'h1);
    end

    // Test 6: tap switch 4 -> 1 mid-stream.
    en = 1'b1; din_valid = 1'b1; lat_sel = 3'd4;
    for (int i = 0; i < 16; i++) begin
      din = 8'(i);
      #1;
      if (i == 10) begin
        check("t6_before_dout", 32'(dout), 32'h06);
        lat_sel = 3'd1;
        #1;
        check("t6_after_dout", 32'(dout), 32'h09);
        check("t6_after_valid", 32'(dout_valid), 32'h1);
        check("t6_after_count", 32'(count), 32'd4);
      end else if (i > 10) begin
        check($sformatf("t6_tap1_%0d_dout", i), 32'(dout), 32'(i - 1));
      end
      tick();
    end

    // Randomized traffic against the reference model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset($sformatf("rnd%0d", n));
      en        = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      din_valid = 1'($urandom_range(0, 1));
      din       = 8'($urandom);
      lat_sel   = 3'($urandom_range(0, 7));
      #2;
      model_check($sformatf("rnd%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_pipe_reg.md
Name: d_pipe_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage registered delay line.
- Adds the following, none of which the plain DFF has:
  - asynchronous active-low reset
  - per-stage valid tracking
  - stall (enable)
  - flush
  - run-time selectable latency tap, including a zero-latency bypass
  - in-flight occupancy count
- Used wherever datapaths need programmable alignment delay.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 4, number of register stages (>=1)
RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits)
LW, $clog2(DEPTH+1), derived width of lat_sel and count (not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; 0 = stall (all stages hold)
flush  input  1  synchronous clear of all valid bits
din_valid  input  1  qualifies din
din  input  WIDTH  input data
lat_sel  input  LW  selected latency in cycles, 0..DEPTH
dout  output  WIDTH  data at selected tap
dout_valid  output  1  valid at selected tap
count  output  LW  number of stages currently holding valid data (0..DEPTH)

Behaviour:
- Internal state:
  - Data stages s[0..DEPTH-1].
  - Valid bits v[0..DEPTH-1].
  - Registered count.
- Reset (rst_n=0, asynchronous, takes effect immediately, independent of clk):
  - every s[i] = RESET_VAL
  - every v[i] = 0
  - count = 0
  - Deassertion is synchronous to clk.
- Per rising clk edge, priority: flush > en > hold.
  - flush=1:
    - all v[i] <= 0; count <= 0.
    - s[i] hold their values.
    - din and din_valid are NOT captured, even with en=1.
  - flush=0, en=1 (shift):
    - s[0] <= din; v[0] <= din_valid.
    - s[i] <= s[i-1] and v[i] <= v[i-1] for i = 1..DEPTH-1.
    - Data shifts regardless of valid; bubbles (din_valid=0) propagate as invalid slots.
    - The oldest stage is discarded.
  - flush=0, en=0 (hold): all s, v and count hold.
- count:
  - Registered; always equals the popcount of v after the edge.
  - On shift: count_next = count + din_valid - v[DEPTH-1].
  - Saturation is impossible by construction (range 0..DEPTH).
- Output tap (combinational from lat_sel, state and inputs):
  - lat_sel = 0: bypass. dout = din, dout_valid = din_valid & ~flush; zero latency.
  - lat_sel = k, 1 <= k <= DEPTH: dout = s[k-1], dout_valid = v[k-1].
  - lat_sel > DEPTH: clamped; behaves as lat_sel = DEPTH.
  - Reset is asserted: dout = RESET_VAL, dout_valid = 0. Bypass is also forced to this while reset is asserted.
- Latency: with en held at 1, a word presented at edge n appears at dout with tap k after edge n+k-1, i.e. during cycle n+k.
- Changing lat_sel mid-stream:
  - Switches the tap immediately, in the same cycle.
  - No realignment; words may be skipped or repeated at the output.
  - Occupancy is unaffected.
- Stall with lat_sel = 0: bypass still passes din through, since it is combinational.
- Reset mid-operation: all in-flight data is discarded; the first valid word after release obeys normal latency.
- DEPTH = 1: LW = 1; lat_sel is either 0 (bypass) or 1 (one stage).
- Implementation: synthesisable non-blocking sequential logic, no latches. Combinational output must not feed back into state.

Test Plan:
1. Reset and stream: assert rst_n=0 mid-cycle.
   - Required response: dout=0, dout_valid=0 and count=0 immediately.
   - Then release reset, set lat_sel=3, en=1, feed din=0x11,0x22,0x33,0x44 valid on consecutive edges.
   - Required response: 0x11 appears with dout_valid=1 in the cycle after the third edge. Outputs follow in order, and count reaches 4 after the 4th edge.
2. Stall: mid-stream, drive en=0 for 2 cycles with din=0xAA valid.
   - Required response: dout, dout_valid and count frozen.
   - 0xAA is not captured.
   - The stream resumes in order after en returns to 1.
3. Bubbles and count: feed valid, invalid, valid (0x01,--,0x03) with DEPTH=4.
   - Required response: count goes 1,1,2; the invalid slot surfaces with dout_valid=0 at tap 2.
   - Continuing with din_valid=0 until every valid word exits: count decrements back to 0.
4. Flush priority: with 4 valid words in flight, pulse flush=1 together with en=1 and din_valid=1 (din=0x55).
   - Required response: after the edge, count=0 and all tap valids are 0.
   - 0x55 is never output as valid.
5. Bypass and clamp:
   - lat_sel=0, din=0x7E valid: dout=0x7E, dout_valid=1 in the same cycle. With flush=1 as well: dout_valid=0.
   - lat_sel=7 with DEPTH=4: output identical to lat_sel=4.
6. Mid-stream tap switch: stream an incrementing count of 0x00..0x0F and change lat_sel 4→1.
   - Required response: dout jumps to the newest word in the same cycle.
   - count is unchanged by the switch.
